// File: rtl/reg_file_ctrl.sv
// Register file sequencing controller: clears x1..x(N-1) after reset, owns the
// single write port, merges writeback and debug writes, and borrows rs2 for debug reads.
module reg_file_ctrl #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] pipe_addr_rs2,
  input  logic                  core_halted,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_write,
  input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
  input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
  output logic                  dbg_rsp_valid,
  input  logic                  dbg_rsp_ready,
  output logic [DATA_WIDTH-1:0] dbg_rsp_rdata,
  input  logic [DATA_WIDTH-1:0] rf_data_rs2,
  output logic [ADDR_WIDTH-1:0] rf_addr_rs2,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_addr_rd,
  output logic [DATA_WIDTH-1:0] rf_data_rd,
  output logic                  ctrl_busy
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DBG_RD,
    DBG_WR,
    DBG_RSP
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_idx_q, init_idx_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic                    req_write_q, req_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d         = state_q;
    init_idx_d      = init_idx_q;
    req_addr_d      = req_addr_q;
    req_wdata_d     = req_wdata_q;
    req_write_d     = req_write_q;
    rsp_rdata_d     = rsp_rdata_q;
    rf_addr_rs2     = pipe_addr_rs2;
    // Writeback passes straight through unless a state below claims the port.
    rf_write_enable = wb_valid && (wb_addr != '0);
    rf_addr_rd      = wb_addr;
    rf_data_rd      = wb_data;
    dbg_req_ready   = 1'b0;
    dbg_rsp_valid   = 1'b0;
    ctrl_busy       = 1'b0;

    unique case (state_q)
      INIT: begin
        ctrl_busy       = 1'b1;
        rf_write_enable = 1'b1;
        rf_addr_rd      = init_idx_q;
        rf_data_rd      = '0;
        if (init_idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          init_idx_d = init_idx_q + FIRST_IDX;
        end
      end
      IDLE: begin
        dbg_req_ready = core_halted;
        if (dbg_req_valid && core_halted) begin
          req_addr_d  = dbg_req_addr;
          req_wdata_d = dbg_req_wdata;
          req_write_d = dbg_req_write;
          state_d     = dbg_req_write ? DBG_WR : DBG_RD;
        end
      end
      DBG_RD: begin
        rf_addr_rs2 = req_addr_q;
        rsp_rdata_d = (req_addr_q == '0) ? '0 : rf_data_rs2;
        state_d     = DBG_RSP;
      end
      DBG_WR: begin
        // A pending writeback keeps the port; the debug write waits a cycle.
        if (!wb_valid) begin
          rf_write_enable = (req_addr_q != '0);
          rf_addr_rd      = req_addr_q;
          rf_data_rd      = req_wdata_q;
          rsp_rdata_d     = '0;
          state_d         = DBG_RSP;
        end
      end
      DBG_RSP: begin
        dbg_rsp_valid = 1'b1;
        if (dbg_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      init_idx_q  <= FIRST_IDX;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_write_q <= req_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign dbg_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Scoreboard bench for reg_file_ctrl: stimulus queues expected write-port strobes
// and debug responses; a negedge monitor pops and compares them with cycle stamps.
module tb_reg_file_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  pipe_addr_rs2;
  logic        core_halted;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_write;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_rdata;
  logic [31:0] rf_data_rs2;
  logic [4:0]  rf_addr_rs2;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic        ctrl_busy;

  reg_file_ctrl #(.NUM_REGS(32), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .pipe_addr_rs2(pipe_addr_rs2), .core_halted(core_halted),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
    .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdata(dbg_rsp_rdata),
    .rf_data_rs2(rf_data_rs2), .rf_addr_rs2(rf_addr_rs2),
    .rf_write_enable(rf_write_enable), .rf_addr_rd(rf_addr_rd),
    .rf_data_rd(rf_data_rd), .ctrl_busy(ctrl_busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file model; x0 deliberately returns garbage so the DUT must zero it.
  logic [31:0] rf_mem [32];
  always @(posedge clock) if (rf_write_enable) rf_mem[rf_addr_rd] <= rf_data_rd;
  assign rf_data_rs2 = (rf_addr_rs2 == 5'd0) ? 32'hBAD0_BAD0 : rf_mem[rf_addr_rs2];

  typedef struct {int unsigned cyc; logic [4:0] addr; logic [31:0] data;} wr_t;
  typedef struct {int unsigned cyc; logic [31:0] data;} rsp_t;
  wr_t  wr_q[$];
  rsp_t rsp_q[$];
  wr_t  wr_e;
  rsp_t rsp_e;

  int vectors = 0;
  int miscompares = 0;

  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (rf_write_enable) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL rf_write: unexpected write cyc=%0d addr=%0d data=%h, required no write",
                   cyc, rf_addr_rd, rf_data_rd);
        end else begin
          wr_e = wr_q.pop_front();
          if (cyc != wr_e.cyc || rf_addr_rd !== wr_e.addr || rf_data_rd !== wr_e.data) begin
            miscompares++;
            $display("FAIL rf_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                     cyc, rf_addr_rd, rf_data_rd, wr_e.cyc, wr_e.addr, wr_e.data);
          end
        end
      end
      if (dbg_rsp_valid && dbg_rsp_ready) begin
        vectors++;
        if (rsp_q.size() == 0) begin
          miscompares++;
          $display("FAIL dbg_rsp: unexpected response cyc=%0d rdata=%h", cyc, dbg_rsp_rdata);
        end else begin
          rsp_e = rsp_q.pop_front();
          if (cyc != rsp_e.cyc || dbg_rsp_rdata !== rsp_e.data) begin
            miscompares++;
            $display("FAIL dbg_rsp: got cyc=%0d rdata=%h, required cyc=%0d rdata=%h",
                     cyc, dbg_rsp_rdata, rsp_e.cyc, rsp_e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int unsigned c, input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_rsp(input int unsigned c, input logic [31:0] d);
    rsp_t r;
    r.cyc = c; r.data = d;
    rsp_q.push_back(r);
  endtask

  // Release reset now and walk the 31-cycle clear sweep; optional wb noise to x5.
  task automatic init_sweep(input logic wb_noise);
    int unsigned p;
    reset = 1'b0;
    p = cyc;
    for (int unsigned i = 1; i <= 31; i++) push_wr(p + i - 1, 5'(i), 32'h0);
    for (int i = 0; i < 31; i++) begin
      wb_valid = wb_noise && (i < 5);
      wb_addr  = 5'd5;
      wb_data  = 32'hAAAA_5555;
      #1;
      check("busy_in_init", 32'(ctrl_busy), 32'd1);
      check("req_ready_in_init", 32'(dbg_req_ready), 32'd0);
      tick();
    end
    wb_valid = 1'b0;
    #1;
    check("busy_after_init", 32'(ctrl_busy), 32'd0);
  endtask

  // Single debug transaction with the consumer always ready; halted drops after acceptance.
  task automatic dbg_txn(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
    int unsigned t;
    core_halted = 1'b1; dbg_rsp_ready = 1'b1;
    dbg_req_valid = 1'b1; dbg_req_write = wr; dbg_req_addr = a; dbg_req_wdata = wd;
    #1;
    check("txn_req_ready", 32'(dbg_req_ready), 32'd1);
    t = cyc;
    if (wr && a != 5'd0) push_wr(t + 1, a, wd);
    push_rsp(t + 2, exp_rd);
    tick();
    dbg_req_valid = 1'b0; core_halted = 1'b0; dbg_req_wdata = 32'hFFFF_0000;
    tick();
    tick();
    #1;
    check("txn_back_idle", 32'(dbg_rsp_valid), 32'd0);
  endtask

  initial begin
    int unsigned t;
    reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; pipe_addr_rs2 = '0;
    core_halted = 1'b1; dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_req_addr = '0;
    dbg_req_wdata = '0; dbg_rsp_ready = 1'b0;

    tick(); tick();
    check("rst_busy", 32'(ctrl_busy), 32'd1);
    check("rst_req_ready", 32'(dbg_req_ready), 32'd0);
    check("rst_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    check("rst_rsp_rdata", dbg_rsp_rdata, 32'd0);
    check("rst_we", 32'(rf_write_enable), 32'd1);
    check("rst_addr_rd", 32'(rf_addr_rd), 32'd1);
    check("rst_data_rd", rf_data_rd, 32'd0);
    tick();
    init_sweep(1'b1);

    // IDLE writeback passthrough, then x0 suppression
    tick();
    core_halted = 1'b0; pipe_addr_rs2 = 5'd12;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    push_wr(cyc, 5'd3, 32'hDEAD_BEEF);
    #1;
    check("idle_wb_we", 32'(rf_write_enable), 32'd1);
    check("idle_wb_addr", 32'(rf_addr_rd), 32'd3);
    check("idle_rs2_pipe", 32'(rf_addr_rs2), 32'd12);
    tick();
    wb_addr = 5'd0; wb_data = 32'h1111_1111;
    #1;
    check("idle_wb_x0", 32'(rf_write_enable), 32'd0);
    tick();
    wb_valid = 1'b0;

    // Debug read of x3, response held for two cycles before ready
    core_halted = 1'b1; dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd3;
    #1;
    check("rd_ready_T", 32'(dbg_req_ready), 32'd1);
    t = cyc;
    push_rsp(t + 4, 32'hDEAD_BEEF);
    tick();
    dbg_req_valid = 1'b0; pipe_addr_rs2 = 5'd20;
    #1;
    check("rd_rs2_T1", 32'(rf_addr_rs2), 32'd3);
    check("rd_ready_T1", 32'(dbg_req_ready), 32'd0);
    check("rd_valid_T1", 32'(dbg_rsp_valid), 32'd0);
    tick();
    check("rd_valid_T2", 32'(dbg_rsp_valid), 32'd1);
    check("rd_rdata_T2", dbg_rsp_rdata, 32'hDEAD_BEEF);
    tick();
    check("rd_hold_T3", 32'(dbg_rsp_valid), 32'd1);
    check("rd_hold_rdata_T3", dbg_rsp_rdata, 32'hDEAD_BEEF);
    tick();
    dbg_rsp_ready = 1'b1;
    tick();
    dbg_rsp_ready = 1'b0;
    #1;
    check("rd_idle_T5", 32'(dbg_rsp_valid), 32'd0);
    check("rd_ready_T5", 32'(dbg_req_ready), 32'd1);

    // Debug write x7 delayed by two writeback cycles to x9
    tick();
    dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd7; dbg_req_wdata = 32'h1234_5678;
    #1;
    check("wr_ready_T", 32'(dbg_req_ready), 32'd1);
    t = cyc;
    tick();
    dbg_req_valid = 1'b0; dbg_req_wdata = 32'hCAFE_F00D;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h9999_0009;
    push_wr(t + 1, 5'd9, 32'h9999_0009);
    tick();
    push_wr(t + 2, 5'd9, 32'h9999_0009);
    #1;
    check("wr_valid_T2", 32'(dbg_rsp_valid), 32'd0);
    tick();
    wb_valid = 1'b0; dbg_rsp_ready = 1'b1;
    push_wr(t + 3, 5'd7, 32'h1234_5678);
    push_rsp(t + 4, 32'h0);
    tick();
    check("wr_valid_T4", 32'(dbg_rsp_valid), 32'd1);
    tick();

    // Not halted: requests are never accepted
    core_halted = 1'b0; dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd8;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("nohalt_ready", 32'(dbg_req_ready), 32'd0);
      tick();
    end
    dbg_req_valid = 1'b0;
    tick();

    dbg_txn(1'b0, 5'd0, 32'h0, 32'h0);
    dbg_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0);
    dbg_txn(1'b0, 5'd7, 32'h0, 32'h1234_5678);
    dbg_txn(1'b0, 5'd9, 32'h0, 32'h9999_0009);

    // Reset while a response is pending in DBG_RSP
    tick();
    core_halted = 1'b1; dbg_rsp_ready = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd3;
    tick();
    dbg_req_valid = 1'b0;
    tick();
    check("rstrsp_valid_T2", 32'(dbg_rsp_valid), 32'd1);
    reset = 1'b1;
    tick();
    dbg_rsp_ready = 1'b1;
    #1;
    check("rstrsp_valid_drop", 32'(dbg_rsp_valid), 32'd0);
    check("rstrsp_addr_rd", 32'(rf_addr_rd), 32'd1);
    init_sweep(1'b0);

    tick(); tick();
    check("wr_queue_drained", wr_q.size(), 32'd0);
    check("rsp_queue_drained", rsp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
